// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: arbitrates one frame-buffer RAM port, giving display reads priority over buffered draw writes
module vga_fb_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT = 1
) (
  input  logic                          clk,
  input  logic                          clr_n,
  input  logic                          disp_rd_req,
  input  logic [ADDR_W-1:0]             disp_rd_addr,
  output logic [DATA_W-1:0]             disp_rd_data,
  output logic                          disp_rd_valid,
  input  logic                          vblank,
  input  logic                          blank_only,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   stall_cnt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RD, WR} cmd_t;
  cmd_t cmd_q, cmd_d;
  logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] f_data [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [RD_LAT:0] tag;
  logic push, pop, pending;
  assign wr_ready = fifo_level != (PW+1)'(FIFO_DEPTH);
  assign push = wr_valid & wr_ready;
  assign pending = fifo_level != '0;
  assign pop = cmd_d == WR;
  assign mem_en = cmd_q != IDLE;
  assign mem_we = cmd_q == WR;
  always_comb cmd_d = disp_rd_req ? RD : (pending && (!blank_only || vblank)) ? WR : IDLE;
  always_ff @(posedge clk)
    if (push) begin
      f_addr[wp] <= wr_addr;
      f_data[wp] <= wr_data;
    end
  // tag[i] marks a read issued i+1 edges ago; tag[RD_LAT] lines up with mem_rdata
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      cmd_q <= IDLE;
      mem_addr <= '0;
      mem_wdata <= '0;
      wp <= '0;
      rp <= '0;
      fifo_level <= '0;
      tag <= '0;
      disp_rd_valid <= 1'b0;
      disp_rd_data <= '0;
      stall_cnt <= '0;
    end else begin
      cmd_q <= cmd_d;
      if (cmd_d == RD) mem_addr <= disp_rd_addr;
      else if (cmd_d == WR) begin
        mem_addr <= f_addr[rp];
        mem_wdata <= f_data[rp];
      end
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      fifo_level <= fifo_level + (PW+1)'(push) - (PW+1)'(pop);
      tag <= {tag[RD_LAT-1:0], cmd_d == RD};
      disp_rd_valid <= tag[RD_LAT];
      if (tag[RD_LAT]) disp_rd_data <= mem_rdata;
      if (pending && !pop && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench; a queue-based FIFO/memory model predicts every RAM command and read return
module tb_vga_fb_arbiter;
  logic clk = 1'b0, clr_n = 1'b0;
  logic disp_rd_req = 1'b0, vblank = 1'b0, blank_only = 1'b0, wr_valid = 1'b0;
  logic [16:0] disp_rd_addr = '0, wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] mem_rdata, disp_rd_data, mem_wdata;
  logic disp_rd_valid, wr_ready, mem_en, mem_we;
  logic [16:0] mem_addr;
  logic [2:0] fifo_level;
  logic [15:0] stall_cnt;

  vga_fb_arbiter dut (
    .clk(clk), .clr_n(clr_n), .disp_rd_req(disp_rd_req), .disp_rd_addr(disp_rd_addr),
    .disp_rd_data(disp_rd_data), .disp_rd_valid(disp_rd_valid), .vblank(vblank),
    .blank_only(blank_only), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .fifo_level(fifo_level), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic en; logic we; logic [16:0] addr; logic [7:0] wd; logic [2:0] lvl; logic rdy; logic [15:0] stall;} exp_t;
  typedef struct packed {logic [16:0] a; logic [7:0] d;} wr_t;
  typedef struct packed {logic [7:0] d; int due;} rd_t;

  exp_t exp_q[$];
  wr_t mq[$];
  rd_t rd_q[$];
  logic [7:0] ref_mem [0:511];
  logic [7:0] ram [0:511];
  logic ram_vld [0:511];
  int n_cmp = 0, n_err = 0, edge_n = 0, stall = 0;

  function automatic logic [7:0] init_val(input logic [8:0] a);
    return 8'(a * 3) ^ 8'hA5;
  endfunction

  // RAM with one-cycle registered read; untouched words read as init_val
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[8:0]] <= mem_wdata;
        ram_vld[mem_addr[8:0]] <= 1'b1;
      end else
        mem_rdata <= (ram_vld[mem_addr[8:0]] === 1'b1) ? ram[mem_addr[8:0]] : init_val(mem_addr[8:0]);
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    rd_t r;
    #1;
    if (clr_n) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("mem_en", mem_en, e.en);
        check("mem_we", mem_we, e.we);
        if (e.en) check("mem_addr", mem_addr, e.addr);
        if (e.we) check("mem_wdata", mem_wdata, e.wd);
        check("fifo_level", fifo_level, e.lvl);
        check("wr_ready", wr_ready, e.rdy);
        check("stall_cnt", stall_cnt, e.stall);
      end
      if (rd_q.size() != 0 && rd_q[0].due == edge_n) begin
        r = rd_q.pop_front();
        check("rd_valid", disp_rd_valid, 1);
        check("rd_data", disp_rd_data, r.d);
      end else
        check("rd_valid_idle", disp_rd_valid, 0);
    end
  end

  // One cycle of stimulus; the model predicts the command issued at the coming edge
  task automatic cyc(input logic rq, input logic [16:0] ra, input logic vb, input logic bo,
                     input logic wv, input logic [16:0] wa, input logic [7:0] wd);
    exp_t e;
    wr_t w;
    int n;
    logic pop;
    @(negedge clk);
    disp_rd_req = rq; disp_rd_addr = ra; vblank = vb; blank_only = bo;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    n = mq.size();
    pop = !rq && n > 0 && (!bo || vb);
    e = '0;
    e.en = rq || pop;
    e.we = pop;
    if (rq) begin
      e.addr = ra;
      rd_q.push_back('{d: ref_mem[ra[8:0]], due: edge_n + 3});
    end
    if (pop) begin
      w = mq.pop_front();
      e.addr = w.a;
      e.wd = w.d;
      ref_mem[w.a[8:0]] = w.d;
    end
    if (n > 0 && !pop && stall < 65535) stall++;
    if (wv && n < 4) mq.push_back('{a: wa, d: wd});
    e.lvl = 3'(mq.size());
    e.rdy = mq.size() < 4;
    e.stall = 16'(stall);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    disp_rd_req = 1'b0; wr_valid = 1'b0; vblank = 1'b0; blank_only = 1'b0;
    mq.delete(); rd_q.delete(); exp_q.delete(); stall = 0;
    #1;
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rd_valid", disp_rd_valid, 0);
    check("rst_rd_data", disp_rd_data, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_level", fifo_level, 0);
    check("rst_wr_ready", wr_ready, 1);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(9'(i));
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    // reset mid-traffic: three words queued behind blank gating, one read in flight
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 17'h50 + 17'(i), 8'(8'h60 + i));
    cyc(1, 17'h7, 0, 1, 0, 0, 0);
    do_reset();
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
    // read latency: 0x00100 holds 0xA5
    cyc(1, 17'h00100, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    // read priority with two buffered words
    cyc(1, 17'h10, 0, 0, 1, 17'h20, 8'h11);
    cyc(1, 17'h11, 0, 0, 1, 17'h21, 8'h22);
    for (int i = 0; i < 8; i++) cyc(1, 17'(i), 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 17'h20, 0, 0, 0, 0, 0);
    cyc(1, 17'h21, 0, 0, 0, 0, 0);
    // full FIFO under blank gating, fifth word held until vblank
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 1, 17'h30 + 17'(i), 8'(8'hC0 + i));
    repeat (3) cyc(0, 0, 0, 1, 1, 17'h40, 8'h5A);
    cyc(0, 0, 1, 1, 1, 17'h40, 8'h5A);
    repeat (6) cyc(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 17'h30 + 17'(i), 0, 0, 0, 0, 0);
    // randomized traffic with a reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      cyc($urandom_range(0, 3) == 0, 17'($urandom_range(0, 511)), $urandom_range(0, 2) == 0,
          (i / 60) % 2 == 1, $urandom_range(0, 1) == 1, 17'($urandom_range(0, 511)), 8'($urandom));
    end
    repeat (8) cyc(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 512; i += 37) cyc(1, 17'(i), 0, 0, 0, 0, 0);
    // stall counter saturation
    do_reset();
    cyc(0, 0, 0, 1, 1, 17'h99, 8'h3C);
    repeat (70000) cyc(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #2;
    check("stall_sat", stall_cnt, 16'hFFFF);
    repeat (4) cyc(0, 0, 1, 1, 0, 0, 0);
    cyc(1, 17'h99, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("exp_drain", exp_q.size(), 0);
    check("rd_drain", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
